// File: rtl/if_id_pipeline_ctrl.sv
// PC register, IF/ID pipeline register, ID/EX bubble control and stall watchdog for the fetch stage.
// Optional event counters are built when IF_ID_PERF_CNT_EN is defined; otherwise both count ports read zero.
module if_id_pipeline_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_IF_ID,
  input  logic        flush_ID_EX,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        ID_EX_clear,
  output logic        misalign_flag,
  output logic        stall_timeout,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam logic [15:0] MAX_STALL_W = 16'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    state_d       = ST_RUN;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    misalign_d    = 1'b0;
    wd_cnt_d      = 16'd0;

    if (flush_IF_ID) begin
      state_d       = ST_REDIRECT;
      pc_d          = {branch_target[31:2], 2'b00};
      if_id_pc_d    = 32'd0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      misalign_d    = |branch_target[1:0];
    end else if (stall) begin
      state_d  = ST_HOLD;
      // Saturate rather than wrap so a long stall never re-arms a false "not yet" window.
      wd_cnt_d = (wd_cnt_q >= MAX_STALL_W) ? MAX_STALL_W : wd_cnt_q + 16'd1;
    end else begin
      pc_d          = pc_q + 32'd4;
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_instr;
      if_id_valid_d = 1'b1;
    end

    timeout_d = timeout_q | (wd_cnt_d == MAX_STALL_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
      wd_cnt_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misalign_q    <= misalign_d;
      timeout_q     <= timeout_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_IF_ID) flush_cnt_d = flush_cnt_q + 32'd1;
    else if (stall)  stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

  assign pc            = pc_q;
  assign IF_ID_pc      = if_id_pc_q;
  assign IF_ID_instr   = if_id_instr_q;
  assign IF_ID_valid   = if_id_valid_q;
  assign misalign_flag = misalign_q & (state_q == ST_REDIRECT);
  assign stall_timeout = timeout_q;
  assign ID_EX_clear   = flush_ID_EX | (stall & ~flush_IF_ID);

endmodule
